sdpram_pipe: RTL and testbench
==============================

SDPRAM_PIPE -- requirements
Module: sdpram_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of a data word; a multiple of 8 when BYTE_WRITE=1.
REQ-002 SHALL have parameter MEM_DEPTH, default 1024: number of words; not required to be a power of two.
REQ-003 SHALL have parameter BYTE_WRITE, default 0: 1 enables per-byte write strobes.
REQ-004 SHALL have parameter RD_LATENCY, default 1: cycles from read request to read data; legal range 1..3.
REQ-005 SHALL define ADDR_WIDTH = $clog2(MEM_DEPTH) and STRB_WIDTH = BYTE_WRITE ? DATA_WIDTH/8 : 1.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port addra, input, ADDR_WIDTH bits: write address.
REQ-009 SHALL have port wena, input, STRB_WIDTH bits: write enable, one bit per byte lane when BYTE_WRITE=1.
REQ-010 SHALL have port dina, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port addrb, input, ADDR_WIDTH bits: read address.
REQ-012 SHALL have port renb, input, 1 bit: read request.
REQ-013 SHALL have port doutb, output, DATA_WIDTH bits: read data.
REQ-014 SHALL have port dvalb, output, 1 bit: read data valid.

Function
REQ-015 SHALL write lane i of mem[addra] from dina lane i at a clock edge where wena[i]=1; when BYTE_WRITE=0, wena[0] controls the whole word.
REQ-016 SHALL treat a request sampled with renb=1 at edge N as a read, presenting the data on doutb with dvalb=1 for exactly one cycle after edge N+RD_LATENCY-1.
REQ-017 SHALL accept one read per cycle, fully pipelined, with no backpressure; the valid pipeline is RD_LATENCY stages of {valid, data}.
REQ-018 SHALL hold doutb at its last valid value while dvalb=0.
REQ-019 SHALL ignore writes with addra >= MEM_DEPTH; no memory location changes.
REQ-020 SHALL return all-zero data, with dvalb still asserted at normal latency, for reads with addrb >= MEM_DEPTH.
REQ-021 SHALL define read-collision as renb=1 and any wena bit set with addra==addrb in the same cycle; the returned data is defined in the Configuration section.
REQ-022 SHALL, for a read at edge N+1 of an address written at edge N, return the newly written data regardless of configuration.
REQ-023 SHALL NOT let memory contents affect dvalb timing; dvalb depends only on the renb history.

Reset
REQ-024 SHALL, while rst_n=0, immediately force dvalb=0, doutb=0 and all pipeline valid/data stages to 0.
REQ-025 SHALL discard reads in flight when reset asserts mid-operation; none produce dvalb after release.
REQ-026 SHALL NOT initialise or clear memory contents on reset.
REQ-027 SHALL sample renb/wena normally from the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL compile write-to-read forwarding when macro SDPRAM_FWD_EN is defined: on collision the read returns the merged word, with dina lanes where wena=1 and old memory lanes elsewhere.
REQ-029 SHALL, without SDPRAM_FWD_EN, return the full pre-write (old) contents of mem[addrb] on collision.
REQ-030 SHALL have identical latency and dvalb timing with or without SDPRAM_FWD_EN.

Verification
REQ-031 SHALL cover back-to-back reads, RD_LATENCY=2: write 0xA5A5A5A5@5 and 0x12345678@6; renb on cycles 10,11 (addr 5,6) -> dvalb on cycles 12,13 with data 0xA5A5A5A5, 0x12345678.
REQ-032 SHALL cover byte-write, BYTE_WRITE=1: mem[3]=0x11223344; write wena=4'b0101, dina=0xAABBCCDD to addr 3; read 3 -> 0x11BB33DD.
REQ-033 SHALL cover collision: mem[7]=0x0; same cycle write 0xFFFFFFFF@7 (full strobe) and read 7 -> 0xFFFFFFFF with SDPRAM_FWD_EN, 0x00000000 without.
REQ-034 SHALL cover reset mid-flight: RD_LATENCY=3, renb on cycles 20,21; rst_n low cycle 22 for 1 cycle -> dvalb and doutb 0 immediately, no dvalb afterwards.
REQ-035 SHALL cover depth boundary, MEM_DEPTH=1000: write 0xDEADBEEF@1000, then read 1000 -> dvalb=1, data 0; read 999 unchanged.
REQ-036 SHALL cover hold: after a valid read returning 0x5, three idle cycles -> doutb stays 0x5, dvalb=0.

Source files
------------

// File: rtl/sdpram_pipe.sv
// sdpram_pipe: simple dual-port RAM with one write port (A) and one pipelined
// read port (B) on a single clock.
//
// Optional build macro: SDPRAM_FWD_EN
//   defined   - a read that collides with a same-cycle write to the same
//               address returns the merged word (new lanes where written,
//               old lanes elsewhere).
//   undefined - a colliding read returns the old memory contents.
// Latency and dvalb timing are identical in both builds.
//
// The read pipeline is RD_LATENCY stages of {valid, data}. A data stage only
// loads when the stage feeding it is valid. Because of that, doutb keeps its
// last valid value while dvalb is low. Memory contents are never reset.
// Out-of-range writes are dropped, and out-of-range reads return zero at the
// normal latency.

module sdpram_pipe #(
  parameter  int DATA_WIDTH = 32,
  parameter  int MEM_DEPTH  = 1024,
  parameter  int BYTE_WRITE = 0,
  parameter  int RD_LATENCY = 1,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
  localparam int STRB_WIDTH = (BYTE_WRITE != 0) ? DATA_WIDTH / 8 : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [STRB_WIDTH-1:0] wena,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic                  renb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  dvalb
);

  // Width of one write lane: a byte with strobes, the whole word without.
  localparam int          LANE_WIDTH = (BYTE_WRITE != 0) ? 8 : DATA_WIDTH;
  localparam int unsigned DEPTH_U    = MEM_DEPTH;

  // Storage array. It has no reset, so it can map onto RAM macros.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  addra_in_s;
  logic                  addrb_in_s;
  logic                  wr_any_s;
  logic [DATA_WIDTH-1:0] rd_old_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  logic [RD_LATENCY-1:0] vld_r;
  logic [DATA_WIDTH-1:0] dat_r [RD_LATENCY];

`ifdef SDPRAM_FWD_EN
  logic                  coll_s;
  logic [DATA_WIDTH-1:0] fwd_mask_s;

  // Expands the per-lane write strobes into a per-bit mask.
  function automatic logic [DATA_WIDTH-1:0] strb_to_mask(
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      m[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{strb[i]}};
    end
    return m;
  endfunction
`endif

  // Range checks. The address is widened to 32 bits, so the comparison also
  // holds when MEM_DEPTH is not a power of two.
  assign addra_in_s = (32'(addra) < DEPTH_U);
  assign addrb_in_s = (32'(addrb) < DEPTH_U);
  assign wr_any_s   = |wena;

`ifdef SDPRAM_FWD_EN
  assign coll_s     = renb & wr_any_s & addrb_in_s & (addra == addrb);
  assign fwd_mask_s = strb_to_mask(wena);
`endif

  // Write port: update only the strobed lanes of an in-range address.
  always_ff @(posedge clk) begin
    if (wr_any_s && addra_in_s) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wena[i]) begin
          mem[addra][i*LANE_WIDTH +: LANE_WIDTH] <= dina[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Read-side word: old contents (or zero when out of range), with the
  // optional same-cycle merge of the colliding write.
  always_comb begin
    rd_old_s  = '0;
    rd_data_s = '0;
    if (addrb_in_s) begin
      rd_old_s = mem[addrb];
    end else begin
      rd_old_s = '0;
    end
`ifdef SDPRAM_FWD_EN
    if (coll_s) begin
      rd_data_s = (dina & fwd_mask_s) | (rd_old_s & ~fwd_mask_s);
    end else begin
      rd_data_s = rd_old_s;
    end
`else
    rd_data_s = rd_old_s;
`endif
  end

  // Read pipeline. Valid bits shift every cycle, and a data stage loads only
  // behind a valid stage. Reset clears every stage at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dat_r[i] <= '0;
      end
    end else begin
      vld_r[0] <= renb;
      if (renb) begin
        dat_r[0] <= rd_data_s;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        if (vld_r[i-1]) begin
          dat_r[i] <= dat_r[i-1];
        end
      end
    end
  end

  assign doutb = dat_r[RD_LATENCY-1];
  assign dvalb = vld_r[RD_LATENCY-1];

endmodule

// File: tb/tb_sdpram_pipe.sv
// Directed bench for sdpram_pipe.
// Configuration: 32-bit words, MEM_DEPTH=1000, byte strobes, RD_LATENCY=2.
// With a 2-cycle latency, read data is visible one tick after the tick that
// sampled the request.
// Expected collision data follows the SDPRAM_FWD_EN macro.

module tb_sdpram_pipe;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addra;
  logic [SW-1:0] wena;
  logic [DW-1:0] dina;
  logic [AW-1:0] addrb;
  logic          renb;
  logic [DW-1:0] doutb;
  logic          dvalb;

  int n_checks;
  int n_fail;

  sdpram_pipe #(
    .DATA_WIDTH (32),
    .MEM_DEPTH  (1000),
    .BYTE_WRITE (1),
    .RD_LATENCY (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addra (addra),
    .wena  (wena),
    .dina  (dina),
    .addrb (addrb),
    .renb  (renb),
    .doutb (doutb),
    .dvalb (dvalb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
    addra = a;
    dina  = d;
    wena  = s;
    tick();
    wena  = 4'b0000;
  endtask

  // Issue one read, then wait until its data is due on doutb.
  task automatic issue_read(input logic [AW-1:0] a);
    renb  = 1'b1;
    addrb = a;
    tick();
    renb  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if (dvalb !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dvalb: got %b expected 0", dvalb);
    end
    n_checks++;
    if (doutb !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL reset_doutb: got %h expected 00000000", doutb);
    end
  endtask

  task automatic test_back_to_back();
    do_write(10'd5, 32'hA5A5_A5A5, 4'b1111);
    do_write(10'd6, 32'h1234_5678, 4'b1111);
    renb  = 1'b1;
    addrb = 10'd5;
    tick();
    n_checks++;
    if (dvalb !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_early_dvalb: got %b expected 0", dvalb);
    end
    addrb = 10'd6;
    tick();
    renb = 1'b0;
    n_checks++;
    if (dvalb !== 1'b1 || doutb !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL b2b_first: got dvalb=%b doutb=%h expected 1 a5a5a5a5", dvalb, doutb);
    end
    tick();
    n_checks++;
    if (dvalb !== 1'b1 || doutb !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL b2b_second: got dvalb=%b doutb=%h expected 1 12345678", dvalb, doutb);
    end
    tick();
    n_checks++;
    if (dvalb !== 1'b0 || doutb !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL b2b_after: got dvalb=%b doutb=%h expected 0 12345678", dvalb, doutb);
    end
  endtask

  task automatic test_byte_write();
    do_write(10'd3, 32'h1122_3344, 4'b1111);
    do_write(10'd3, 32'hAABB_CCDD, 4'b0101);
    issue_read(10'd3);
    n_checks++;
    if (dvalb !== 1'b1 || doutb !== 32'h11BB_33DD) begin
      n_fail++;
      $display("FAIL byte_write: got dvalb=%b doutb=%h expected 1 11bb33dd", dvalb, doutb);
    end
    tick();
  endtask

  task automatic test_collision();
    logic [DW-1:0] exp_full;
    logic [DW-1:0] exp_part;
`ifdef SDPRAM_FWD_EN
    exp_full = 32'hFFFF_FFFF;
    exp_part = 32'h1122_CCDD;
`else
    exp_full = 32'h0000_0000;
    exp_part = 32'h1122_3344;
`endif
    do_write(10'd7, 32'h0000_0000, 4'b1111);
    do_write(10'd8, 32'h1122_3344, 4'b1111);
    // Full-word collision on address 7.
    addra = 10'd7;
    dina  = 32'hFFFF_FFFF;
    wena  = 4'b1111;
    renb  = 1'b1;
    addrb = 10'd7;
    tick();
    wena = 4'b0000;
    renb = 1'b0;
    tick();
    n_checks++;
    if (dvalb !== 1'b1 || doutb !== exp_full) begin
      n_fail++;
      $display("FAIL coll_full: got dvalb=%b doutb=%h expected 1 %h", dvalb, doutb, exp_full);
    end
    tick();
    // Partial-strobe collision on address 8.
    addra = 10'd8;
    dina  = 32'hAABB_CCDD;
    wena  = 4'b0011;
    renb  = 1'b1;
    addrb = 10'd8;
    tick();
    wena = 4'b0000;
    renb = 1'b0;
    tick();
    n_checks++;
    if (dvalb !== 1'b1 || doutb !== exp_part) begin
      n_fail++;
      $display("FAIL coll_part: got dvalb=%b doutb=%h expected 1 %h", dvalb, doutb, exp_part);
    end
    tick();
    issue_read(10'd8);
    n_checks++;
    if (doutb !== 32'h1122_CCDD) begin
      n_fail++;
      $display("FAIL coll_part_after: got %h expected 1122ccdd", doutb);
    end
    tick();
    issue_read(10'd7);
    n_checks++;
    if (doutb !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL coll_full_after: got %h expected ffffffff", doutb);
    end
    tick();
  endtask

  task automatic test_write_then_read();
    addra = 10'd9;
    dina  = 32'hCAFE_F00D;
    wena  = 4'b1111;
    tick();
    wena  = 4'b0000;
    issue_read(10'd9);
    n_checks++;
    if (dvalb !== 1'b1 || doutb !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL wr_then_rd: got dvalb=%b doutb=%h expected 1 cafef00d", dvalb, doutb);
    end
    tick();
  endtask

  task automatic test_boundary();
    do_write(10'd999, 32'h9999_9999, 4'b1111);
    do_write(10'd1000, 32'hDEAD_BEEF, 4'b1111);
    issue_read(10'd1000);
    n_checks++;
    if (dvalb !== 1'b1 || doutb !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL bound_1000: got dvalb=%b doutb=%h expected 1 00000000", dvalb, doutb);
    end
    tick();
    issue_read(10'd999);
    n_checks++;
    if (dvalb !== 1'b1 || doutb !== 32'h9999_9999) begin
      n_fail++;
      $display("FAIL bound_999: got dvalb=%b doutb=%h expected 1 99999999", dvalb, doutb);
    end
    tick();
    issue_read(10'd1023);
    n_checks++;
    if (dvalb !== 1'b1 || doutb !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL bound_1023: got dvalb=%b doutb=%h expected 1 00000000", dvalb, doutb);
    end
    tick();
  endtask

  task automatic test_hold();
    do_write(10'd2, 32'h0000_0005, 4'b1111);
    issue_read(10'd2);
    n_checks++;
    if (dvalb !== 1'b1 || doutb !== 32'h0000_0005) begin
      n_fail++;
      $display("FAIL hold_read: got dvalb=%b doutb=%h expected 1 00000005", dvalb, doutb);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (dvalb !== 1'b0 || doutb !== 32'h0000_0005) begin
        n_fail++;
        $display("FAIL hold_idle%0d: got dvalb=%b doutb=%h expected 0 00000005", i, dvalb, doutb);
      end
    end
  endtask

  task automatic test_reset_midflight();
    renb  = 1'b1;
    addrb = 10'd5;
    tick();
    addrb = 10'd6;
    tick();
    renb = 1'b0;
    n_checks++;
    if (dvalb !== 1'b1 || doutb !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL mid_pre: got dvalb=%b doutb=%h expected 1 a5a5a5a5", dvalb, doutb);
    end
    // The read of address 6 is still in flight when reset asserts.
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dvalb !== 1'b0 || doutb !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL mid_async: got dvalb=%b doutb=%h expected 0 00000000", dvalb, doutb);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (dvalb !== 1'b0 || doutb !== 32'h0000_0000) begin
        n_fail++;
        $display("FAIL mid_after%0d: got dvalb=%b doutb=%h expected 0 00000000", i, dvalb, doutb);
      end
    end
    // Memory survives reset.
    issue_read(10'd6);
    n_checks++;
    if (dvalb !== 1'b1 || doutb !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL mid_mem_kept: got dvalb=%b doutb=%h expected 1 12345678", dvalb, doutb);
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    addra    = 10'd0;
    wena     = 4'b0000;
    dina     = 32'h0000_0000;
    addrb    = 10'd0;
    renb     = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_back_to_back();
    test_byte_write();
    test_collision();
    test_write_then_read();
    test_boundary();
    test_hold();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
